asyn_fifo_lvl: RTL and testbench

Parametrised dual-clock FIFO. It is the successor to the team's Gray-pointer asynchronous FIFO, and the RAM is inferred internally (no vendor macro).

---
 rtl/asyn_fifo_lvl.sv | 250 +++++++++++++++++++++++++
 tb/tb_asyn_fifo_lvl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/asyn_fifo_lvl.sv
// asyn_fifo_lvl: dual-clock FIFO with Gray-coded pointer crossing, fill-level
// counters in both domains, programmable almost-full/almost-empty flags and an
// optional show-ahead read mode. Storage is an inferred register array.
//
// Write domain (wclk, wrst_n):
//   wr, wdata           write request and data; accepted when wr & ~wfull
//   wfull               registered full flag
//   walmost_full        registered, wlevel >= P_AF_TH
//   wlevel              registered, words stored as seen from the write side
// Read domain (rclk, rrst_n):
//   rd                  read request (normal) / head acknowledge (show-ahead)
//   rdata               registered read data
//   rempty              registered empty flag
//   ralmost_empty       registered, rlevel <= P_AE_TH
//   rlevel              registered, words stored as seen from the read side
//
// Optional build macro ASYN_FIFO_ERR_FLAGS_EN adds the sticky error outputs
// woverflow (wclk) and runderflow (rclk), cleared only by their own reset.
module asyn_fifo_lvl #(
  parameter int unsigned P_DW        = 16,
  parameter int unsigned P_AW        = 4,
  parameter int unsigned P_SYNC      = 2,
  parameter int unsigned P_AF_TH     = 12,
  parameter int unsigned P_AE_TH     = 2,
  parameter int unsigned P_SHOWAHEAD = 0
) (
  input  logic            wclk,
  input  logic            wrst_n,
  input  logic            wr,
  input  logic [P_DW-1:0] wdata,
  output logic            wfull,
  output logic            walmost_full,
  output logic [P_AW:0]   wlevel,
  input  logic            rclk,
  input  logic            rrst_n,
  input  logic            rd,
  output logic [P_DW-1:0] rdata,
  output logic            rempty,
  output logic            ralmost_empty,
  output logic [P_AW:0]   rlevel
`ifdef ASYN_FIFO_ERR_FLAGS_EN
  ,
  output logic            woverflow,
  output logic            runderflow
`endif
);

  localparam int unsigned Depth = 2 ** P_AW;

  typedef logic [P_AW:0] ptr_t;

  localparam ptr_t AfTh   = ptr_t'(P_AF_TH);
  localparam ptr_t AeTh   = ptr_t'(P_AE_TH);
  localparam ptr_t PtrOne = ptr_t'(1);

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[P_AW] = g[P_AW];
    for (int i = int'(P_AW) - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Storage: written from wclk only, read from the read domain once the
  // synchronised write pointer shows the slot as filled.
  logic [P_DW-1:0] mem_q [Depth];

  // ---------------------------------------------------------------------------
  // Write domain
  // ---------------------------------------------------------------------------
  ptr_t wbin_q, wbin_d;
  ptr_t wgray_q, wgray_d;
  ptr_t wlevel_q, wlevel_d;
  logic wfull_q, wfull_d;
  logic walmost_full_q, walmost_full_d;
  logic w_accept;
  ptr_t rgray_wsync_q [P_SYNC];
  ptr_t rgray_w;
  ptr_t full_cmp;

  always_comb begin
    w_accept       = wr & ~wfull_q;
    wbin_d         = wbin_q + (w_accept ? PtrOne : '0);
    wgray_d        = bin2gray(wbin_d);
    rgray_w        = rgray_wsync_q[P_SYNC-1];
    // Full: write pointer one lap ahead of read pointer, i.e. Gray codes equal
    // except for the two MSBs.
    full_cmp       = {~rgray_w[P_AW:P_AW-1], rgray_w[P_AW-2:0]};
    wfull_d        = (wgray_d == full_cmp);
    wlevel_d       = wbin_d - gray2bin(rgray_w);
    walmost_full_d = (wlevel_d >= AfTh);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q         <= '0;
      wgray_q        <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= (P_AF_TH == 0);
      wlevel_q       <= '0;
    end else begin
      wbin_q         <= wbin_d;
      wgray_q        <= wgray_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
      wlevel_q       <= wlevel_d;
    end
  end

  // Read-pointer synchroniser into wclk.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int i = 0; i < int'(P_SYNC); i++) rgray_wsync_q[i] <= '0;
    end else begin
      rgray_wsync_q[0] <= rgray_q;
      for (int i = 1; i < int'(P_SYNC); i++) rgray_wsync_q[i] <= rgray_wsync_q[i-1];
    end
  end

  always_ff @(posedge wclk) begin
    if (w_accept) mem_q[wbin_q[P_AW-1:0]] <= wdata;
  end

  assign wfull        = wfull_q;
  assign walmost_full = walmost_full_q;
  assign wlevel       = wlevel_q;

  // ---------------------------------------------------------------------------
  // Read domain
  // ---------------------------------------------------------------------------
  // rbin_q is the committed (popped) read pointer; it is the one published to
  // the write side, so a prefetched word still occupies its slot until popped.
  ptr_t rbin_q, rbin_d;
  ptr_t rgray_q, rgray_d;
  ptr_t rlevel_q, rlevel_d;
  logic rempty_q, rempty_d;
  logic ralmost_empty_q, ralmost_empty_d;
  logic [P_DW-1:0] rdata_q, rdata_d;
  ptr_t wgray_rsync_q [P_SYNC];
  ptr_t wgray_r;
  ptr_t wbin_r;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int i = 0; i < int'(P_SYNC); i++) wgray_rsync_q[i] <= '0;
    end else begin
      wgray_rsync_q[0] <= wgray_q;
      for (int i = 1; i < int'(P_SYNC); i++) wgray_rsync_q[i] <= wgray_rsync_q[i-1];
    end
  end

  assign wgray_r = wgray_rsync_q[P_SYNC-1];
  assign wbin_r  = gray2bin(wgray_r);

  if (P_SHOWAHEAD == 0) begin : g_normal
    logic r_accept;

    always_comb begin
      r_accept = rd & ~rempty_q;
      rbin_d   = rbin_q + (r_accept ? PtrOne : '0);
      rempty_d = (bin2gray(rbin_d) == wgray_r);
      rdata_d  = r_accept ? mem_q[rbin_q[P_AW-1:0]] : rdata_q;
    end
  end else begin : g_showahead
    // fbin_q: next memory slot to move into the prefetch (rdata) register.
    // The prefetch register is valid exactly when rempty_q is low.
    ptr_t fbin_q, fbin_d;
    logic pop;
    logic load;
    logic mem_empty;

    always_comb begin
      pop       = rd & ~rempty_q;
      mem_empty = (bin2gray(fbin_q) == wgray_r);
      // Refill whenever the head register is empty or being popped this edge,
      // so a back-to-back pop sees the next word without a bubble.
      load      = (rempty_q | pop) & ~mem_empty;
      fbin_d    = fbin_q + (load ? PtrOne : '0);
      rbin_d    = rbin_q + (pop ? PtrOne : '0);
      rempty_d  = ~load & (rempty_q | pop);
      rdata_d   = load ? mem_q[fbin_q[P_AW-1:0]] : rdata_q;
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) fbin_q <= '0;
      else         fbin_q <= fbin_d;
    end
  end

  always_comb begin
    rgray_d         = bin2gray(rbin_d);
    rlevel_d        = wbin_r - rbin_d;
    ralmost_empty_d = (rlevel_d <= AeTh);
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q          <= '0;
      rgray_q         <= '0;
      rempty_q        <= 1'b1;
      ralmost_empty_q <= 1'b1;
      rlevel_q        <= '0;
      rdata_q         <= '0;
    end else begin
      rbin_q          <= rbin_d;
      rgray_q         <= rgray_d;
      rempty_q        <= rempty_d;
      ralmost_empty_q <= ralmost_empty_d;
      rlevel_q        <= rlevel_d;
      rdata_q         <= rdata_d;
    end
  end

  assign rdata         = rdata_q;
  assign rempty        = rempty_q;
  assign ralmost_empty = ralmost_empty_q;
  assign rlevel        = rlevel_q;

`ifdef ASYN_FIFO_ERR_FLAGS_EN
  // ---------------------------------------------------------------------------
  // Sticky error flags
  // ---------------------------------------------------------------------------
  logic woverflow_q, woverflow_d;
  logic runderflow_q, runderflow_d;

  always_comb begin
    woverflow_d  = woverflow_q | (wr & wfull_q);
    runderflow_d = runderflow_q | (rd & rempty_q);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) woverflow_q <= 1'b0;
    else         woverflow_q <= woverflow_d;
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) runderflow_q <= 1'b0;
    else         runderflow_q <= runderflow_d;
  end

  assign woverflow  = woverflow_q;
  assign runderflow = runderflow_q;
`endif

endmodule

// File: tb/tb_asyn_fifo_lvl.sv
// Self-checking bench for asyn_fifo_lvl: directed fill/drain, latency,
// overflow/underflow, mid-operation reset and show-ahead cases, followed by a
// randomized transfer run checked against a queue reference model.
`timescale 1ns/1ps
module tb_asyn_fifo_lvl;

  localparam int unsigned Dw    = 16;
  localparam int unsigned Aw    = 4;
  localparam int unsigned Depth = 16;
  localparam int unsigned NRand = 1100;

  realtime whalf = 5.0;
  realtime rhalf = 13.514;

  logic wclk = 1'b0;
  logic rclk = 1'b0;
  logic wrst_n = 1'b0;
  logic rrst_n = 1'b0;

  always #(whalf) wclk = ~wclk;
  always #(rhalf) rclk = ~rclk;

  // Default instance
  logic          wr = 1'b0, rd = 1'b0;
  logic [Dw-1:0] wdata = '0, rdata;
  logic          wfull, walmost_full, rempty, ralmost_empty;
  logic [Aw:0]   wlevel, rlevel;
  // Show-ahead instance, 4-flop synchroniser
  logic          sa_wr = 1'b0, sa_rd = 1'b0;
  logic [Dw-1:0] sa_wdata = '0, sa_rdata;
  logic          sa_wfull, sa_walmost_full, sa_rempty, sa_ralmost_empty;
  logic [Aw:0]   sa_wlevel, sa_rlevel;
`ifdef ASYN_FIFO_ERR_FLAGS_EN
  logic          woverflow, runderflow, sa_woverflow, sa_runderflow;
`endif

  asyn_fifo_lvl u_dut (
    .wclk          (wclk),
    .wrst_n        (wrst_n),
    .wr            (wr),
    .wdata         (wdata),
    .wfull         (wfull),
    .walmost_full  (walmost_full),
    .wlevel        (wlevel),
    .rclk          (rclk),
    .rrst_n        (rrst_n),
    .rd            (rd),
    .rdata         (rdata),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
    .rlevel        (rlevel)
`ifdef ASYN_FIFO_ERR_FLAGS_EN
    ,
    .woverflow     (woverflow),
    .runderflow    (runderflow)
`endif
  );

  asyn_fifo_lvl #(
    .P_SYNC      (4),
    .P_SHOWAHEAD (1)
  ) u_sa (
    .wclk          (wclk),
    .wrst_n        (wrst_n),
    .wr            (sa_wr),
    .wdata         (sa_wdata),
    .wfull         (sa_wfull),
    .walmost_full  (sa_walmost_full),
    .wlevel        (sa_wlevel),
    .rclk          (rclk),
    .rrst_n        (rrst_n),
    .rd            (sa_rd),
    .rdata         (sa_rdata),
    .rempty        (sa_rempty),
    .ralmost_empty (sa_ralmost_empty),
    .rlevel        (sa_rlevel)
`ifdef ASYN_FIFO_ERR_FLAGS_EN
    ,
    .woverflow     (sa_woverflow),
    .runderflow    (sa_runderflow)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [Dw-1:0] model_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Both resets together; release slightly apart.
  task automatic do_reset();
    wr = 1'b0; rd = 1'b0; sa_wr = 1'b0; sa_rd = 1'b0;
    wrst_n = 1'b0; rrst_n = 1'b0;
    repeat (3) @(posedge rclk);
    #1 wrst_n = 1'b1;
    #3 rrst_n = 1'b1;
    repeat (3) @(posedge rclk);
    #1;
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_wfull"}, wfull, 0);
    check({pfx, "_walmost_full"}, walmost_full, 0);
    check({pfx, "_wlevel"}, wlevel, 0);
    check({pfx, "_rempty"}, rempty, 1);
    check({pfx, "_ralmost_empty"}, ralmost_empty, 1);
    check({pfx, "_rlevel"}, rlevel, 0);
    check({pfx, "_rdata"}, rdata, 0);
`ifdef ASYN_FIFO_ERR_FLAGS_EN
    check({pfx, "_woverflow"}, woverflow, 0);
    check({pfx, "_runderflow"}, runderflow, 0);
`endif
  endtask

  task automatic push_words(input logic [Dw-1:0] base, input int cnt);
    @(posedge wclk); #1;
    for (int k = 0; k < cnt; k++) begin
      wr = 1'b1; wdata = base + Dw'(k);
      @(posedge wclk); #1;
    end
    wr = 1'b0;
  endtask

  task automatic pop_words(input string tag, input logic [Dw-1:0] base, input int cnt);
    @(posedge rclk); #1;
    for (int k = 0; k < cnt; k++) begin
      rd = 1'b1;
      @(posedge rclk); #1;
      check(tag, rdata, base + Dw'(k));
    end
    rd = 1'b0;
  endtask

  task automatic rand_writer(input int n);
    int sent = 0;
    int cyc  = 0;
    @(posedge wclk); #1;
    while (sent < n && cyc < 20000) begin
      check("rand_wlevel_max", wlevel <= Depth, 1);
      wdata = Dw'($urandom);
      wr    = (sent < n) && ($urandom_range(0, 9) < 7);
      if (wr && !wfull) begin
        model_q.push_back(wdata);
        sent++;
      end
      @(posedge wclk); #1;
      cyc++;
    end
    wr = 1'b0;
    check("rand_wr_done", sent, n);
  endtask

  task automatic rand_reader(input int n);
    int popped = 0;
    int got_n  = 0;
    int cyc    = 0;
    logic pend = 1'b0;
    logic [Dw-1:0] exp_d = '0;
    while (got_n < n && cyc < 6000) begin
      @(posedge rclk); #1;
      cyc++;
      if (pend) begin
        check("rand_data", rdata, exp_d);
        got_n++;
        pend = 1'b0;
      end
      check("rand_rlevel_bound", (rlevel <= Depth) && (rlevel <= model_q.size()), 1);
      rd = (popped < n) && ($urandom_range(0, 9) < 8);
      if (rd && !rempty) begin
        exp_d = model_q.pop_front();
        pend  = 1'b1;
        popped++;
      end
    end
    rd = 1'b0;
    check("rand_rd_done", got_n, n);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Reset state
    do_reset();
    check_reset_vals("rst");
    check("rst_sa_rempty", sa_rempty, 1);
    check("rst_sa_rlevel", sa_rlevel, 0);
    check("rst_sa_rdata", sa_rdata, 0);
    check("rst_sa_wfull", sa_wfull, 0);
    check("rst_sa_walmost_full", sa_walmost_full, 0);
    check("rst_sa_ralmost_empty", sa_ralmost_empty, 1);

    // Fill with 1..16, check level and flags after each accept
    @(posedge wclk); #1;
    for (int k = 1; k <= 16; k++) begin
      wr = 1'b1; wdata = Dw'(k);
      @(posedge wclk); #1;
      check("fill_wlevel", wlevel, k);
      check("fill_walmost_full", walmost_full, (k >= 12));
      check("fill_wfull", wfull, (k == 16));
    end
    wr = 1'b0;
    repeat (4) @(posedge rclk); #1;
    check("full_rempty", rempty, 0);
    check("full_rlevel", rlevel, 16);
    check("full_ralmost_empty", ralmost_empty, 0);

    // Drain in order
    for (int k = 1; k <= 16; k++) begin
      rd = 1'b1;
      @(posedge rclk); #1;
      check("drain_rdata", rdata, k);
      check("drain_rlevel", rlevel, 16 - k);
      check("drain_ralmost_empty", ralmost_empty, ((16 - k) <= 2));
      check("drain_rempty", rempty, (k == 16));
    end
    rd = 1'b0;
    repeat (4) @(posedge wclk); #1;
    check("drained_wlevel", wlevel, 0);
    check("drained_wfull", wfull, 0);
    check("drained_walmost_full", walmost_full, 0);

    // Write-to-not-empty latency, P_SYNC=2
    @(posedge wclk); #1; wr = 1'b1; wdata = 16'h0077;
    @(posedge wclk); #1; wr = 1'b0;
    n = 0;
    while (rempty && n < 12) begin
      @(posedge rclk); #1; n++;
    end
    check("lat_sync2_le3", (n <= 3), 1);
    check("lat_sync2_rempty", rempty, 0);
    rd = 1'b1; @(posedge rclk); #1; rd = 1'b0;
    check("lat_sync2_rdata", rdata, 16'h0077);
    check("lat_sync2_empty_after", rempty, 1);

    // Show-ahead, P_SYNC=4: head word visible before any rd
    @(posedge wclk); #1; sa_wr = 1'b1; sa_wdata = 16'h00A5;
    @(posedge wclk); #1; sa_wr = 1'b0;
    n = 0;
    while (sa_rempty && n < 12) begin
      @(posedge rclk); #1; n++;
    end
    check("sa_lat_le5", (n <= 5), 1);
    check("sa_rempty_fell", sa_rempty, 0);
    check("sa_head_a5", sa_rdata, 16'h00A5);
    check("sa_rlevel1", sa_rlevel, 1);
    @(posedge wclk); #1; sa_wr = 1'b1; sa_wdata = 16'h005A;
    @(posedge wclk); #1; sa_wr = 1'b0;
    n = 0;
    while (sa_rlevel != 2 && n < 12) begin
      @(posedge rclk); #1; n++;
    end
    check("sa_rlevel2", sa_rlevel, 2);
    check("sa_head_still_a5", sa_rdata, 16'h00A5);
    sa_rd = 1'b1; @(posedge rclk); #1; sa_rd = 1'b0;
    check("sa_pop_next_5a", sa_rdata, 16'h005A);
    check("sa_pop_rempty", sa_rempty, 0);
    check("sa_pop_rlevel", sa_rlevel, 1);
    sa_rd = 1'b1; @(posedge rclk); #1; sa_rd = 1'b0;
    check("sa_last_rempty", sa_rempty, 1);
    check("sa_last_rlevel", sa_rlevel, 0);
    repeat (6) @(posedge wclk); #1;
    check("sa_wlevel0", sa_wlevel, 0);

    // Overflow: full FIFO, keep writing 0xDEAD
    push_words(16'h0100, 16);
    wr = 1'b1; wdata = 16'hDEAD;
    for (int k = 0; k < 5; k++) begin
      @(posedge wclk); #1;
      check("ovf_wlevel", wlevel, 16);
      check("ovf_wfull", wfull, 1);
    end
    wr = 1'b0;
    repeat (4) @(posedge rclk); #1;
    pop_words("ovf_rdata", 16'h0100, 16);
    check("ovf_rempty", rempty, 1);
    // Read while empty: ignored, rdata holds
    rd = 1'b1; @(posedge rclk); #1; rd = 1'b0;
    check("udf_rdata_hold", rdata, 16'h010F);
    check("udf_rempty", rempty, 1);
    check("udf_rlevel", rlevel, 0);
`ifdef ASYN_FIFO_ERR_FLAGS_EN
    check("ovf_sticky", woverflow, 1);
    check("udf_sticky", runderflow, 1);
`endif

    // Mid-operation reset with 8 words stored
    push_words(16'h0200, 8);
    check("half_wlevel", wlevel, 8);
    do_reset();
    check_reset_vals("midrst");
    push_words(16'h1234, 1);
    repeat (4) @(posedge rclk); #1;
    check("midrst_rlevel1", rlevel, 1);
    pop_words("midrst_first", 16'h1234, 1);
    check("midrst_rempty", rempty, 1);

    // Randomized simultaneous traffic, clock ratio 3:7
    whalf = 3.0;
    rhalf = 7.0;
    do_reset();
    model_q.delete();
    fork
      rand_writer(NRand);
      rand_reader(NRand);
    join
    repeat (5) @(posedge rclk); #1;
    check("rand_model_empty", model_q.size(), 0);
    check("rand_end_rempty", rempty, 1);
    check("rand_end_rlevel", rlevel, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
